arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: data width per channel in bits.
REQ-002 SHALL provide parameter NCH, default 4: number of input channels, legal range 2..8.
REQ-003 SHALL provide parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-004 SHALL derive localparam SEL_W = clog2(NCH), minimum 1.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-009 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
REQ-011 out_valid  output  1  registered output word is present.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready (combinational).
REQ-016 SHALL compute a one-hot grant among channels with in_valid high, combinationally, every cycle.
REQ-017 RR=0: grant SHALL go to the lowest-index valid channel.
REQ-018 RR=1: grant SHALL go to the first valid channel searching upward from ptr+1, wrapping NCH-1 -> 0; ptr is a SEL_W-bit register.
REQ-019 in_ready[i] SHALL equal grant[i] && load_en; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-020 On a transfer, at the next clk edge out_data <= in_data[channel], out_sel <= channel, out_valid <= 1 (latency one cycle).
REQ-021 On load_en with no valid input, out_valid SHALL clear to 0 at the next edge; out_data and out_sel SHALL hold.
REQ-022 While out_valid && !out_ready, out_valid, out_data and out_sel SHALL hold stable and all in_ready SHALL be 0.
REQ-023 Simultaneous out_ready and new transfer SHALL replace the word in the same edge: one word per cycle sustained throughput, no bubble.
REQ-024 RR=1: ptr SHALL update to the granted index only on a transfer; on stall or idle ptr SHALL hold.
REQ-025 RR=0: ptr SHALL remain at its reset value and be unused.
REQ-026 A channel whose in_valid drops before its transfer SHALL lose the grant without affecting ptr.
REQ-027 When NCH is not a power of two, ptr SHALL never take a value >= NCH; wrap from NCH-1 SHALL go to 0.
REQ-028 No combinational path SHALL exist from out_ready to out_data/out_sel/out_valid; out_ready reaches in_ready only through load_en.

Reset
REQ-029 Reset assertion SHALL immediately force out_valid=0, out_data=0, out_sel=0, ptr=NCH-1 (channel 0 first after reset).
REQ-030 in_ready SHALL be 0 while rst is high; a word held at reset SHALL be discarded, not delivered.
REQ-031 First transfer SHALL be possible on the first rising clk edge after rst deasserts.

Verification
REQ-032 Reset: assert rst mid-stall with out_valid=1 -> out_valid, out_data, out_sel read 0 before next clk edge; ptr=3 (NCH=4).
REQ-033 Round-robin: RR=1, NCH=4, in_valid=4'b1111 constant, out_ready=1, in_data ch i = 32'hA0+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 32'hA0..A3,A0.
REQ-034 Fixed priority: RR=0, in_valid=4'b1010, out_ready=1 -> channel 1 granted every cycle, out_sel=1; channel 3 starves.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0100 -> in_ready=0, out_data stable; out_ready=1 -> in_ready[2]=1 same cycle, new word next edge.
REQ-036 Wrap/non-power-of-two: NCH=3, RR=1, ptr=2, in_valid=3'b011 -> grant channel 0, then channel 1, ptr never reads 3.
REQ-037 Idle drain: single transfer then in_valid=0, out_ready=1 -> out_valid high exactly one cycle, out_data held after drop.

Source files
------------

// File: rtl/arb_mux.sv
// Multi-channel arbiter feeding a single registered output word with valid/ready
// handshakes; round-robin or fixed-priority selection.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int RR    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH-1:0]                 in_valid,
  input  logic [NCH*WIDTH-1:0]           in_data,
  output logic [NCH-1:0]                 in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  output logic [((NCH > 2) ? $clog2(NCH) : 1)-1:0] out_sel,
  input  logic                           out_ready
);

  localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gsel;
  logic [SEL_W-1:0] cand;
  logic [SEL_W:0]   sum;
  logic [NCH-1:0]   grant;
  logic             gany;
  logic [WIDTH-1:0] gdata;
  logic             load_en;

  // Grant search: upward from ptr+1 with wrap at NCH (round-robin), or from 0.
  always_comb begin
    grant = '0;
    gsel  = '0;
    gany  = 1'b0;
    cand  = '0;
    sum   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR != 0) begin
        sum = {1'b0, ptr} + (SEL_W+1)'(k + 1);
        if (sum >= (SEL_W+1)'(NCH)) sum = sum - (SEL_W+1)'(NCH);
        cand = sum[SEL_W-1:0];
      end else begin
        cand = SEL_W'(k);
      end
      if (!gany && in_valid[cand]) begin
        grant[cand] = 1'b1;
        gsel        = cand;
        gany        = 1'b1;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {NCH{load_en}});

  // Output register stage: a stalled word holds; ptr advances only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(NCH - 1);
    end else if (load_en) begin
      out_valid <= gany;
      if (gany) begin
        out_data <= gdata;
        out_sel  <= gsel;
        if (RR != 0) ptr <= gsel;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: three instances (RR NCH=4, fixed NCH=4,
// RR NCH=3) compared every cycle against a behavioural model.
module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   iv0, iv1;
  logic [2:0]   iv2;
  logic         rdy0, rdy1, rdy2;
  logic [127:0] d4;
  logic [3:0]   ir0, ir1;
  logic [2:0]   ir2;
  logic         ov0, ov1, ov2;
  logic [31:0]  od0, od1, od2;
  logic [1:0]   os0, os1, os2;

  int nassert = 0;
  int nfail   = 0;

  int          nch_m[3] = '{4, 4, 3};
  int          rr_m[3]  = '{1, 0, 1};
  logic        m_valid[3];
  logic [31:0] m_data[3];
  int          m_sel[3];
  int          m_ptr[3];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .NCH(4), .RR(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(d4), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(rdy0));
  arb_mux #(.WIDTH(32), .NCH(4), .RR(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_data(d4), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(rdy1));
  arb_mux #(.WIDTH(32), .NCH(3), .RR(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_data(d4[95:0]), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(rdy2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec rule: first requesting channel starting after ptr (wrapping), or lowest index.
  function automatic int mgrant(input int n, input int rr, input int p, input logic [3:0] v);
    if (rr == 0) begin
      for (int c = 0; c < n; c++) if (v[c]) return c;
    end else begin
      for (int k = 1; k <= n; k++) if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_sel[i]   = 0;
      m_ptr[i]   = nch_m[i] - 1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " dut0 out_valid"}, 64'(ov0), 64'd0);
    chk({tag, " dut0 out_data"}, 64'(od0), 64'd0);
    chk({tag, " dut0 out_sel"}, 64'(os0), 64'd0);
    chk({tag, " dut0 ptr"}, 64'(dut0.ptr), 64'd3);
    chk({tag, " dut2 ptr"}, 64'(dut2.ptr), 64'd2);
    chk({tag, " dut1 out_valid"}, 64'(ov1), 64'd0);
    chk({tag, " dut2 out_valid"}, 64'(ov2), 64'd0);
    chk({tag, " in_ready"}, {53'd0, ir2, ir1, ir0}, 64'd0);
  endtask

  task automatic check_outs();
    chk("dut0 out_valid", 64'(ov0), 64'(m_valid[0]));
    chk("dut0 out_data",  64'(od0), 64'(m_data[0]));
    chk("dut0 out_sel",   64'(os0), 64'(m_sel[0]));
    chk("dut0 ptr",       64'(dut0.ptr), 64'(m_ptr[0]));
    chk("dut1 out_valid", 64'(ov1), 64'(m_valid[1]));
    chk("dut1 out_data",  64'(od1), 64'(m_data[1]));
    chk("dut1 out_sel",   64'(os1), 64'(m_sel[1]));
    chk("dut1 ptr",       64'(dut1.ptr), 64'(m_ptr[1]));
    chk("dut2 out_valid", 64'(ov2), 64'(m_valid[2]));
    chk("dut2 out_data",  64'(od2), 64'(m_data[2]));
    chk("dut2 out_sel",   64'(os2), 64'(m_sel[2]));
    chk("dut2 ptr",       64'(dut2.ptr), 64'(m_ptr[2]));
    chk("dut2 ptr range", 64'(dut2.ptr < 2'd3), 64'd1);
  endtask

  // One clock cycle: in_ready checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    logic [3:0] v[3];
    logic       r[3];
    logic [3:0] irr[3];
    int         g;
    logic       le;
    @(negedge clk);
    v[0] = iv0;  v[1] = iv1;  v[2] = {1'b0, iv2};
    r[0] = rdy0; r[1] = rdy1; r[2] = rdy2;
    irr[0] = ir0; irr[1] = ir1; irr[2] = {1'b0, ir2};
    for (int i = 0; i < 3; i++) begin
      g  = mgrant(nch_m[i], rr_m[i], m_ptr[i], v[i]);
      le = !m_valid[i] || r[i];
      chk($sformatf("dut%0d in_ready", i), 64'(irr[i]), (g >= 0 && le) ? (64'd1 << g) : 64'd0);
      if (le) begin
        if (g >= 0) begin
          m_valid[i] = 1'b1;
          m_data[i]  = d4[g*32 +: 32];
          m_sel[i]   = g;
          if (rr_m[i] != 0) m_ptr[i] = g;
        end else begin
          m_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    iv0 = 4'hF; iv1 = 4'hF; iv2 = 3'b111;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    model_reset();
    #2;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin rotation, fixed priority starvation, NCH=3 wrap.
    iv1 = 4'b1010;
    iv2 = 3'b011;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr sequence sel", 64'(os0), 64'(exp_rr[k]));
      chk("rr sequence data", 64'(od0), 64'(32'hA0 + exp_rr[k]));
      chk("fixed prio sel", 64'(os1), 64'd1);
    end

    // Backpressure with only channel 2 requesting.
    iv0 = 4'b0100;
    rdy0 = 1'b0;
    d4[64 +: 32] = 32'h5555_0002;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall data", 64'(od0), 64'(32'hA0));
    end
    rdy0 = 1'b1;
    step();
    chk("after stall data", 64'(od0), 64'(32'h5555_0002));
    chk("after stall sel", 64'(os0), 64'd2);

    // Single transfer then idle drain.
    iv0 = 4'b0001;
    d4[0 +: 32] = 32'hDEAD_0000;
    step();
    iv0 = 4'b0000;
    step();
    chk("drain valid low", 64'(ov0), 64'd0);
    chk("drain data held", 64'(od0), 64'(32'hDEAD_0000));
    step();

    // Randomised traffic, including requests that drop before being granted.
    for (int n = 0; n < 400; n++) begin
      iv0 = 4'($urandom);
      iv1 = 4'($urandom);
      iv2 = 3'($urandom);
      rdy0 = ($urandom_range(3) != 0);
      rdy1 = ($urandom_range(3) != 0);
      rdy2 = ($urandom_range(1) != 0);
      d4 = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    // Reset asserted mid-stall with a word held.
    iv0 = 4'hF; iv1 = 4'hF; iv2 = 3'b111;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    step();
    step();
    chk("pre-reset held valid", 64'(ov0), 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("async rst");
    @(posedge clk);
    #1;
    check_reset_state("rst held");
    rst = 1'b0;
    d4 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    step();
    chk("first after reset sel", 64'(os0), 64'd0);
    chk("first after reset data", 64'(od0), 64'(32'hB0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
